sequencer_phy_mgr_mc: RTL and testbench

- Single-clock, multi-group PHY manager. An Avalon-MM slave owned by the sequencer NIOS; it sits between the sequencer bus and the per-DQS-group read-path/VFIFO logic.
- Generalises the PHY manager to NUM_GROUPS channels with per-group read latency, full register readback, and multi-pulse VFIFO increment commands.
- Adds a sticky error status for bad group indices.

---
 rtl/sequencer_phy_mgr_mc_pkg.sv | 44 ++++
 rtl/sequencer_phy_mgr_pulse_gen.sv | 60 ++++++
 rtl/sequencer_phy_mgr_mc.sv | 253 +++++++++++++++++++++++++
 tb/tb_sequencer_phy_mgr_mc.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sequencer_phy_mgr_mc_pkg.sv
// Shared types and address map for the multi-group PHY manager.
package sequencer_phy_mgr_mc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_PULSE,
    ST_GAP,
    ST_DONE
  } mgr_state_e;

  typedef enum logic [1:0] {
    TGT_FR,
    TGT_HR,
    TGT_FIFO
  } pulse_tgt_e;

  localparam logic [3:0] REGION_ISSUE = 4'b0010;
  localparam logic [3:0] REGION_RFILE = 4'b0011;

  localparam logic [7:0] OFS_LAT_ALL    = 8'h00;
  localparam logic [7:0] OFS_MEM_STABLE = 8'h01;
  localparam logic [7:0] OFS_MUX_SEL    = 8'h02;
  localparam logic [7:0] OFS_CAL_STATUS = 8'h03;
  localparam logic [7:0] OFS_DEBUG      = 8'h04;
  localparam logic [7:0] OFS_OVERRIDE   = 8'h05;
  localparam logic [7:0] OFS_WLAT       = 8'h06;
  localparam logic [7:0] OFS_RLAT       = 8'h07;
  localparam logic [7:0] OFS_LAT_BASE   = 8'h08;
  localparam logic [7:0] OFS_STATUS     = 8'hF0;

  localparam logic [7:0] ISS_INC_FR   = 8'h00;
  localparam logic [7:0] ISS_INC_HR   = 8'h01;
  localparam logic [7:0] ISS_FIFO_RST = 8'h02;
  localparam logic [7:0] ISS_CLR_ERR  = 8'h03;

  localparam logic [7:0] GROUP_ALL = 8'hFF;

  // A repeat count of zero still issues one pulse.
  function automatic logic [7:0] eff_count(input logic [7:0] n);
    return (n == 8'd0) ? 8'd1 : n;
  endfunction

endpackage

// File: rtl/sequencer_phy_mgr_pulse_gen.sv
// Emits count single-cycle copies of mask, separated by gap idle cycles,
// with a done strobe coinciding with the final pulse.
module sequencer_phy_mgr_pulse_gen
  import sequencer_phy_mgr_mc_pkg::*;
#(
  parameter int NUM_GROUPS = 8,
  parameter int GAP_WIDTH  = 2
) (
  input  logic                  avl_clk,
  input  logic                  avl_reset_n,
  input  logic                  start,
  input  logic [NUM_GROUPS-1:0] mask,
  input  logic [7:0]            count,
  input  logic [GAP_WIDTH-1:0]  gap,
  output logic [NUM_GROUPS-1:0] pulse,
  output logic                  done,
  output logic                  gap_end
);

  logic                  pulsing_q;
  logic                  gapping_q;
  logic [NUM_GROUPS-1:0] mask_q;
  logic [7:0]            remaining_q;
  logic [GAP_WIDTH-1:0]  gap_cnt_q;

  assign pulse   = pulsing_q ? mask_q : '0;
  assign done    = pulsing_q && (remaining_q == 8'd1);
  // A zero gap is treated as one so the engine can never stall in the gap.
  assign gap_end = gapping_q && (gap_cnt_q <= GAP_WIDTH'(1));

  always_ff @(posedge avl_clk) begin
    if (!avl_reset_n) begin
      pulsing_q   <= 1'b0;
      gapping_q   <= 1'b0;
      mask_q      <= '0;
      remaining_q <= '0;
      gap_cnt_q   <= '0;
    end else if (start) begin
      pulsing_q   <= 1'b1;
      gapping_q   <= 1'b0;
      mask_q      <= mask;
      remaining_q <= eff_count(count);
    end else if (pulsing_q) begin
      pulsing_q   <= 1'b0;
      remaining_q <= remaining_q - 8'd1;
      if (remaining_q != 8'd1) begin
        gapping_q <= 1'b1;
        gap_cnt_q <= gap;
      end
    end else if (gapping_q) begin
      if (gap_end) begin
        gapping_q <= 1'b0;
        pulsing_q <= 1'b1;
      end else begin
        gap_cnt_q <= gap_cnt_q - GAP_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/sequencer_phy_mgr_mc.sv
// Multi-group PHY manager: Avalon-MM register file plus VFIFO/FIFO command issue.
//   state    | meaning
//   IDLE     | waiting for a selected read or write
//   APPLY    | register file written; PHY outputs load on the exit edge
//   PULSE    | current command mask driven for one cycle
//   GAP      | idle spacing between successive pulses
//   DONE     | waitrequest released; hold until the master drops the request
module sequencer_phy_mgr_mc
  import sequencer_phy_mgr_mc_pkg::*;
#(
  parameter int AVL_DATA_WIDTH = 32,
  parameter int AVL_ADDR_WIDTH = 16,
  parameter int NUM_GROUPS     = 8,
  parameter int LAT_WIDTH      = 5,
  parameter int WLAT_WIDTH     = 6,
  parameter int RLAT_WIDTH     = 6,
  parameter int DEBUG_WIDTH    = 32,
  parameter int PULSE_GAP      = 2
) (
  input  logic                            avl_clk,
  input  logic                            avl_reset_n,
  input  logic [AVL_ADDR_WIDTH-1:0]       avl_address,
  input  logic                            avl_write,
  input  logic [AVL_DATA_WIDTH-1:0]       avl_writedata,
  input  logic                            avl_read,
  output logic [AVL_DATA_WIDTH-1:0]       avl_readdata,
  output logic                            avl_waitrequest,
  output logic [NUM_GROUPS*LAT_WIDTH-1:0] phy_read_latency_counter,
  output logic [NUM_GROUPS-1:0]           phy_read_increment_vfifo_fr,
  output logic [NUM_GROUPS-1:0]           phy_read_increment_vfifo_hr,
  output logic [NUM_GROUPS-1:0]           phy_read_fifo_reset,
  output logic                            phy_reset_mem_stable,
  output logic                            phy_mux_sel,
  output logic                            phy_cal_success,
  output logic                            phy_cal_fail,
  output logic [DEBUG_WIDTH-1:0]          phy_cal_debug_info,
  output logic [NUM_GROUPS-1:0]           phy_vfifo_rd_en_override,
  output logic [WLAT_WIDTH-1:0]           phy_afi_wlat,
  output logic [RLAT_WIDTH-1:0]           phy_afi_rlat
);

  localparam int GAP_WIDTH = (PULSE_GAP < 2) ? 1 : $clog2(PULSE_GAP + 1);

  mgr_state_e state_q, state_d;
  pulse_tgt_e tgt_q;

  logic [3:0] region;
  logic [7:0] ofs;
  logic       sel_issue, sel_rfile, sel;

  logic [LAT_WIDTH-1:0]   lat_q [NUM_GROUPS];
  logic                   mem_stable_q, mux_sel_q, cal_success_q, cal_fail_q;
  logic [DEBUG_WIDTH-1:0] debug_q;
  logic [NUM_GROUPS-1:0]  override_q;
  logic [WLAT_WIDTH-1:0]  wlat_q;
  logic [RLAT_WIDTH-1:0]  rlat_q;
  logic                   err_q;

  logic [AVL_DATA_WIDTH-1:0] rd_d, rd_q;
  logic                      rf_we, iss_we, rd_cap;

  logic [7:0]            iss_grp, iss_cnt, pg_count;
  logic                  grp_all, grp_ok, iss_pulse_cmd, iss_start, iss_bad;
  logic [NUM_GROUPS-1:0] iss_mask, pg_pulse;
  logic                  pg_done, pg_gap_end;
  logic                  unused_ok;

  assign region    = avl_address[AVL_ADDR_WIDTH-1 -: 4];
  assign ofs       = avl_address[7:0];
  assign sel_issue = (region == REGION_ISSUE);
  assign sel_rfile = (region == REGION_RFILE);
  assign sel       = (sel_issue || sel_rfile) && (avl_read || avl_write);
  assign unused_ok = ^{avl_address, avl_writedata};

  // Write wins over a simultaneous read.
  assign rf_we  = (state_q == ST_IDLE) && sel_rfile && avl_write;
  assign iss_we = (state_q == ST_IDLE) && sel_issue && avl_write;
  assign rd_cap = (state_q == ST_IDLE) && sel && !avl_write;

  assign iss_grp       = avl_writedata[7:0];
  assign iss_cnt       = avl_writedata[15:8];
  assign grp_all       = (iss_grp == GROUP_ALL);
  assign grp_ok        = grp_all || (int'(iss_grp) < NUM_GROUPS);
  assign iss_pulse_cmd = (ofs == ISS_INC_FR) || (ofs == ISS_INC_HR) || (ofs == ISS_FIFO_RST);
  assign iss_start     = iss_we && iss_pulse_cmd && grp_ok;
  assign iss_bad       = iss_we && iss_pulse_cmd && !grp_ok;
  assign pg_count      = (ofs == ISS_FIFO_RST) ? 8'd1 : iss_cnt;

  always_comb begin
    iss_mask = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      iss_mask[g] = grp_all || (int'(iss_grp) == g);
    end
  end

  always_ff @(posedge avl_clk) begin
    if (!avl_reset_n) begin
      for (int g = 0; g < NUM_GROUPS; g++) lat_q[g] <= '0;
      mem_stable_q  <= 1'b0;
      mux_sel_q     <= 1'b1;
      cal_success_q <= 1'b0;
      cal_fail_q    <= 1'b0;
      debug_q       <= '0;
      override_q    <= '0;
      wlat_q        <= '0;
      rlat_q        <= '0;
      err_q         <= 1'b0;
    end else begin
      if (rf_we) begin
        case (ofs)
          OFS_LAT_ALL: begin
            for (int g = 0; g < NUM_GROUPS; g++) lat_q[g] <= avl_writedata[LAT_WIDTH-1:0];
          end
          OFS_MEM_STABLE: mem_stable_q <= avl_writedata[0];
          OFS_MUX_SEL:    mux_sel_q    <= avl_writedata[0];
          OFS_CAL_STATUS: begin
            cal_success_q <= avl_writedata[0];
            cal_fail_q    <= avl_writedata[1];
          end
          OFS_DEBUG:    debug_q    <= avl_writedata[DEBUG_WIDTH-1:0];
          OFS_OVERRIDE: override_q <= NUM_GROUPS'(avl_writedata);
          OFS_WLAT:     wlat_q     <= avl_writedata[WLAT_WIDTH-1:0];
          OFS_RLAT:     rlat_q     <= avl_writedata[RLAT_WIDTH-1:0];
          default: begin
            for (int g = 0; g < NUM_GROUPS; g++) begin
              if ((int'(ofs) == int'(OFS_LAT_BASE) + g) && (ofs != OFS_STATUS))
                lat_q[g] <= avl_writedata[LAT_WIDTH-1:0];
            end
          end
        endcase
      end
      if (iss_bad) err_q <= 1'b1;
      else if (iss_we && (ofs == ISS_CLR_ERR)) err_q <= 1'b0;
    end
  end

  // PHY-facing copies lag the register file by one edge.
  always_ff @(posedge avl_clk) begin
    if (!avl_reset_n) begin
      phy_read_latency_counter <= '0;
      phy_reset_mem_stable     <= 1'b0;
      phy_mux_sel              <= 1'b1;
      phy_cal_success          <= 1'b0;
      phy_cal_fail             <= 1'b0;
      phy_cal_debug_info       <= '0;
      phy_vfifo_rd_en_override <= '0;
      phy_afi_wlat             <= '0;
      phy_afi_rlat             <= '0;
    end else if (state_q == ST_APPLY) begin
      for (int g = 0; g < NUM_GROUPS; g++)
        phy_read_latency_counter[g*LAT_WIDTH +: LAT_WIDTH] <= lat_q[g];
      phy_reset_mem_stable     <= mem_stable_q;
      phy_mux_sel              <= mux_sel_q;
      phy_cal_success          <= cal_success_q;
      phy_cal_fail             <= cal_fail_q;
      phy_cal_debug_info       <= debug_q;
      phy_vfifo_rd_en_override <= override_q;
      phy_afi_wlat             <= wlat_q;
      phy_afi_rlat             <= rlat_q;
    end
  end

  always_comb begin
    rd_d = '0;
    if (sel_issue) begin
      case (ofs)
        8'h00:   rd_d = AVL_DATA_WIDTH'(NUM_GROUPS);
        8'h01:   rd_d = AVL_DATA_WIDTH'(LAT_WIDTH);
        8'h02:   rd_d = AVL_DATA_WIDTH'(WLAT_WIDTH);
        8'h03:   rd_d = AVL_DATA_WIDTH'(RLAT_WIDTH);
        default: rd_d = '0;
      endcase
    end else if (sel_rfile) begin
      case (ofs)
        OFS_LAT_ALL:    rd_d = AVL_DATA_WIDTH'(lat_q[0]);
        OFS_MEM_STABLE: rd_d = AVL_DATA_WIDTH'(mem_stable_q);
        OFS_MUX_SEL:    rd_d = AVL_DATA_WIDTH'(mux_sel_q);
        OFS_CAL_STATUS: rd_d = AVL_DATA_WIDTH'({cal_fail_q, cal_success_q});
        OFS_DEBUG:      rd_d = AVL_DATA_WIDTH'(debug_q);
        OFS_OVERRIDE:   rd_d = AVL_DATA_WIDTH'(override_q);
        OFS_WLAT:       rd_d = AVL_DATA_WIDTH'(wlat_q);
        OFS_RLAT:       rd_d = AVL_DATA_WIDTH'(rlat_q);
        OFS_STATUS:     rd_d = AVL_DATA_WIDTH'(err_q);
        default: begin
          for (int g = 0; g < NUM_GROUPS; g++) begin
            if (int'(ofs) == int'(OFS_LAT_BASE) + g) rd_d = AVL_DATA_WIDTH'(lat_q[g]);
          end
        end
      endcase
    end
  end

  always_ff @(posedge avl_clk) begin
    if (!avl_reset_n) begin
      rd_q    <= '0;
      tgt_q   <= TGT_FR;
      state_q <= ST_IDLE;
    end else begin
      if (rd_cap) rd_q <= rd_d;
      if (iss_start) begin
        case (ofs)
          ISS_INC_FR: tgt_q <= TGT_FR;
          ISS_INC_HR: tgt_q <= TGT_HR;
          default:    tgt_q <= TGT_FIFO;
        endcase
      end
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (sel && avl_write) begin
          if (sel_rfile)      state_d = ST_APPLY;
          else if (iss_start) state_d = ST_PULSE;
          else                state_d = ST_DONE;
        end else if (sel) begin
          state_d = ST_DONE;
        end
      end
      ST_APPLY: state_d = ST_DONE;
      ST_PULSE: state_d = pg_done ? ST_DONE : ST_GAP;
      ST_GAP:   state_d = pg_gap_end ? ST_PULSE : ST_GAP;
      ST_DONE:  if (!sel) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  sequencer_phy_mgr_pulse_gen #(
    .NUM_GROUPS (NUM_GROUPS),
    .GAP_WIDTH  (GAP_WIDTH)
  ) u_pulse_gen (
    .avl_clk     (avl_clk),
    .avl_reset_n (avl_reset_n),
    .start       (iss_start),
    .mask        (iss_mask),
    .count       (pg_count),
    .gap         (GAP_WIDTH'(PULSE_GAP)),
    .pulse       (pg_pulse),
    .done        (pg_done),
    .gap_end     (pg_gap_end)
  );

  assign phy_read_increment_vfifo_fr = (tgt_q == TGT_FR)   ? pg_pulse : '0;
  assign phy_read_increment_vfifo_hr = (tgt_q == TGT_HR)   ? pg_pulse : '0;
  assign phy_read_fifo_reset         = (tgt_q == TGT_FIFO) ? pg_pulse : '0;

  assign avl_waitrequest = sel && (state_q != ST_DONE);
  assign avl_readdata    = (sel && avl_read) ? rd_q : '0;

endmodule

// File: tb/tb_sequencer_phy_mgr_mc.sv
// Directed bench for sequencer_phy_mgr_mc with default parameters.
module tb_sequencer_phy_mgr_mc;
  import sequencer_phy_mgr_mc_pkg::*;

  logic        avl_clk = 1'b0;
  logic        avl_reset_n;
  logic [15:0] avl_address;
  logic        avl_write;
  logic [31:0] avl_writedata;
  logic        avl_read;
  logic [31:0] avl_readdata;
  logic        avl_waitrequest;
  logic [39:0] phy_read_latency_counter;
  logic [7:0]  phy_read_increment_vfifo_fr;
  logic [7:0]  phy_read_increment_vfifo_hr;
  logic [7:0]  phy_read_fifo_reset;
  logic        phy_reset_mem_stable;
  logic        phy_mux_sel;
  logic        phy_cal_success;
  logic        phy_cal_fail;
  logic [31:0] phy_cal_debug_info;
  logic [7:0]  phy_vfifo_rd_en_override;
  logic [5:0]  phy_afi_wlat;
  logic [5:0]  phy_afi_rlat;

  always #5 avl_clk = ~avl_clk;

  sequencer_phy_mgr_mc dut (
    .avl_clk                     (avl_clk),
    .avl_reset_n                 (avl_reset_n),
    .avl_address                 (avl_address),
    .avl_write                   (avl_write),
    .avl_writedata               (avl_writedata),
    .avl_read                    (avl_read),
    .avl_readdata                (avl_readdata),
    .avl_waitrequest             (avl_waitrequest),
    .phy_read_latency_counter    (phy_read_latency_counter),
    .phy_read_increment_vfifo_fr (phy_read_increment_vfifo_fr),
    .phy_read_increment_vfifo_hr (phy_read_increment_vfifo_hr),
    .phy_read_fifo_reset         (phy_read_fifo_reset),
    .phy_reset_mem_stable        (phy_reset_mem_stable),
    .phy_mux_sel                 (phy_mux_sel),
    .phy_cal_success             (phy_cal_success),
    .phy_cal_fail                (phy_cal_fail),
    .phy_cal_debug_info          (phy_cal_debug_info),
    .phy_vfifo_rd_en_override    (phy_vfifo_rd_en_override),
    .phy_afi_wlat                (phy_afi_wlat),
    .phy_afi_rlat                (phy_afi_rlat)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] fr_log   [16];
  logic [7:0] hr_log   [16];
  logic [7:0] fifo_log [16];
  logic       wr_log   [16];

  logic [31:0] rdata;
  int          stall;
  int          first_low;
  logic [7:0]  acc;
  logic [39:0] exp_lat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [31:0] data, output int st);
    bit got = 0;
    @(negedge avl_clk);
    avl_address = addr;
    avl_read    = 1'b1;
    st   = 0;
    data = '0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!avl_waitrequest) begin
        data = avl_readdata;
        got  = 1;
        break;
      end
      st++;
      @(negedge avl_clk);
    end
    avl_read = 1'b0;
    if (!got) begin
      n_assert++;
      n_fail++;
      $display("FAIL read_timeout addr %h: waitrequest still high, required low", addr);
    end
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [31:0] data, output int st);
    bit got = 0;
    @(negedge avl_clk);
    avl_address   = addr;
    avl_writedata = data;
    avl_write     = 1'b1;
    st = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!avl_waitrequest) begin
        got = 1;
        break;
      end
      st++;
      @(negedge avl_clk);
    end
    avl_write = 1'b0;
    if (!got) begin
      n_assert++;
      n_fail++;
      $display("FAIL write_timeout addr %h: waitrequest still high, required low", addr);
    end
  endtask

  // Logs 16 cycles of pulse outputs and waitrequest, dropping the write once released.
  task automatic run_issue(input logic [7:0] ofs, input logic [15:0] data);
    @(negedge avl_clk);
    avl_address   = {8'h20, ofs};
    avl_writedata = {16'h0000, data};
    avl_write     = 1'b1;
    for (int c = 0; c < 16; c++) begin
      #1;
      fr_log[c]   = phy_read_increment_vfifo_fr;
      hr_log[c]   = phy_read_increment_vfifo_hr;
      fifo_log[c] = phy_read_fifo_reset;
      wr_log[c]   = avl_waitrequest;
      if (!avl_waitrequest) avl_write = 1'b0;
      @(negedge avl_clk);
    end
    avl_write = 1'b0;
    first_low = -1;
    for (int c = 0; c < 16; c++) if (!wr_log[c] && first_low < 0) first_low = c;
  endtask

  initial begin
    avl_reset_n   = 1'b0;
    avl_address   = '0;
    avl_write     = 1'b0;
    avl_writedata = '0;
    avl_read      = 1'b0;
    repeat (3) @(negedge avl_clk);
    avl_reset_n = 1'b1;
    #1;
    chk("rst_mux_sel", phy_mux_sel, 1);
    chk("rst_latency", phy_read_latency_counter, 0);
    chk("rst_fr", phy_read_increment_vfifo_fr, 0);
    chk("rst_waitreq", avl_waitrequest, 0);
    chk("rst_cal_success", phy_cal_success, 0);

    bus_read(16'h3002, rdata, stall);
    chk("rd_mux_sel", rdata, 1);
    chk("rd_mux_sel_stall", stall, 1);
    bus_read(16'h2000, rdata, stall);
    chk("rd_num_groups", rdata, 8);
    chk("rd_num_groups_stall", stall, 1);
    bus_read(16'h2001, rdata, stall);
    chk("rd_lat_width", rdata, 5);
    bus_read(16'h2003, rdata, stall);
    chk("rd_rlat_width", rdata, 6);
    bus_read(16'h2004, rdata, stall);
    chk("rd_issue_unmapped", rdata, 0);
    bus_read(16'h1002, rdata, stall);
    chk("rd_unselected_data", rdata, 0);
    chk("rd_unselected_stall", stall, 0);

    bus_write(16'h3000, 32'h0000_001F, stall);
    chk("wr_bcast_stall", stall, 2);
    bus_write(16'h300D, 32'h0000_0003, stall);
    for (int g = 0; g < 8; g++) exp_lat[g*5 +: 5] = (g == 5) ? 5'h03 : 5'h1F;
    chk("lat_out_vector", phy_read_latency_counter, exp_lat);
    bus_read(16'h3000, rdata, stall);
    chk("rd_lat_ofs0", rdata, 32'h1F);
    bus_read(16'h300D, rdata, stall);
    chk("rd_lat_g5", rdata, 32'h03);
    bus_read(16'h300F, rdata, stall);
    chk("rd_lat_g7", rdata, 32'h1F);

    bus_write(16'h3004, 32'hDEAD_BEEF, stall);
    bus_write(16'h3005, 32'h0000_01A5, stall);
    bus_write(16'h3006, 32'h0000_007F, stall);
    bus_write(16'h3003, 32'h0000_0002, stall);
    bus_write(16'h3080, 32'h0000_00FF, stall);
    chk("debug_out", phy_cal_debug_info, 32'hDEAD_BEEF);
    chk("override_out", phy_vfifo_rd_en_override, 8'hA5);
    chk("wlat_out_trunc", phy_afi_wlat, 6'h3F);
    chk("cal_fail_out", phy_cal_fail, 1);
    chk("cal_success_out", phy_cal_success, 0);
    bus_read(16'h3005, rdata, stall);
    chk("rd_override", rdata, 32'hA5);
    bus_read(16'h3003, rdata, stall);
    chk("rd_cal_status", rdata, 32'h2);
    bus_read(16'h3080, rdata, stall);
    chk("rd_unmapped", rdata, 0);

    run_issue(8'h00, 16'h0302);
    acc = '0;
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("fr_n3_c%0d", c), fr_log[c], (c == 1 || c == 4 || c == 7) ? 8'h04 : 8'h00);
      acc = acc | hr_log[c] | fifo_log[c];
    end
    chk("fr_n3_others_quiet", acc, 0);
    chk("fr_n3_wait_low_cycle", first_low, 8);

    run_issue(8'h01, 16'h00FF);
    chk("hr_all_c0", hr_log[0], 8'h00);
    chk("hr_all_c1", hr_log[1], 8'hFF);
    chk("hr_all_c2", hr_log[2], 8'h00);
    chk("hr_all_wait_low_cycle", first_low, 2);

    run_issue(8'h02, 16'h05FF);
    chk("fifo_rst_c1", fifo_log[1], 8'hFF);
    chk("fifo_rst_c2", fifo_log[2], 8'h00);
    chk("fifo_rst_wait_low_cycle", first_low, 2);

    run_issue(8'h00, 16'h0309);
    acc = '0;
    for (int c = 0; c < 16; c++) acc = acc | fr_log[c] | hr_log[c] | fifo_log[c];
    chk("bad_grp_no_pulse", acc, 0);
    chk("bad_grp_wait_low_cycle", first_low, 1);
    bus_read(16'h30F0, rdata, stall);
    chk("status_err_set", rdata, 1);
    run_issue(8'h03, 16'h0000);
    bus_read(16'h30F0, rdata, stall);
    chk("status_err_clr", rdata, 0);

    @(negedge avl_clk);
    avl_address   = 16'h2000;
    avl_writedata = 32'h0000_0500;
    avl_write     = 1'b1;
    #1;
    chk("rst_cmd_c0_wait", avl_waitrequest, 1);
    @(negedge avl_clk);
    #1;
    chk("rst_cmd_c1_pulse", phy_read_increment_vfifo_fr, 8'h01);
    @(negedge avl_clk);
    #1;
    chk("rst_cmd_c2_gap", phy_read_increment_vfifo_fr, 8'h00);
    avl_reset_n = 1'b0;
    avl_write   = 1'b0;
    @(negedge avl_clk);
    #1;
    chk("rst_cmd_state_idle", dut.state_q, ST_IDLE);
    chk("rst_cmd_latency", phy_read_latency_counter, 0);
    chk("rst_cmd_mux_sel", phy_mux_sel, 1);
    chk("rst_cmd_debug", phy_cal_debug_info, 0);
    chk("rst_cmd_override", phy_vfifo_rd_en_override, 0);
    chk("rst_cmd_wlat", phy_afi_wlat, 0);
    chk("rst_cmd_cal_fail", phy_cal_fail, 0);
    chk("rst_cmd_waitreq", avl_waitrequest, 0);
    avl_reset_n = 1'b1;
    acc = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge avl_clk);
      #1;
      acc = acc | phy_read_increment_vfifo_fr;
    end
    chk("rst_cmd_pulses_stopped", acc, 0);
    bus_read(16'h300D, rdata, stall);
    chk("rst_cmd_rd_lat_g5", rdata, 0);
    bus_read(16'h3002, rdata, stall);
    chk("rst_cmd_rd_mux_sel", rdata, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
